// File: rtl/leaky_relu_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// leaky_relu_stage_if : alpha cascade, activation stream and output FIFO bus
// Revision: 1.0
// ----------------------------------------------------------------------------
interface leaky_relu_stage_if #(
  parameter int DATA_W = 16
);
  logic              lr_load_alpha_in;
  logic [DATA_W-1:0] lr_alpha_in;
  logic [DATA_W-1:0] lr_alpha_out;
  logic [DATA_W-1:0] lr_data_in;
  logic              lr_valid_in;
  logic              lr_backward_in;
  logic              lr_mask_clear_in;
  logic [DATA_W-1:0] lr_data_out;
  logic              lr_valid_out;
  logic              lr_ready_in;
  logic              lr_overflow_out;
  logic              lr_underflow_out;

  modport slave (
    input  lr_load_alpha_in, lr_alpha_in, lr_data_in, lr_valid_in,
           lr_backward_in, lr_mask_clear_in, lr_ready_in,
    output lr_alpha_out, lr_data_out, lr_valid_out,
           lr_overflow_out, lr_underflow_out
  );

  modport master (
    output lr_load_alpha_in, lr_alpha_in, lr_data_in, lr_valid_in,
           lr_backward_in, lr_mask_clear_in, lr_ready_in,
    input  lr_alpha_out, lr_data_out, lr_valid_out,
           lr_overflow_out, lr_underflow_out
  );
endinterface
`default_nettype wire

// File: rtl/leaky_relu_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// leaky_relu_stage : leaky ReLU / gradient masking with a fall-through output FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
module leaky_relu_stage #(
  parameter int DATA_W     = 16,
  parameter int FRAC       = 8,
  parameter int OUT_DEPTH  = 8,
  parameter int MASK_DEPTH = 64
) (
  input  wire logic         clk,
  input  wire logic         rst,
  leaky_relu_stage_if.slave bus
);

  localparam int c_prod_w  = 2 * DATA_W;
  localparam int c_out_aw  = $clog2(OUT_DEPTH);
  localparam int c_mask_aw = $clog2(MASK_DEPTH);
  localparam logic signed [c_prod_w-1:0] c_sat_max =
    {{(c_prod_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [c_prod_w-1:0] c_sat_min =
    {{(c_prod_w-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [c_out_aw:0]  c_out_full  = (c_out_aw+1)'(OUT_DEPTH);
  localparam logic [c_mask_aw:0] c_mask_full = (c_mask_aw+1)'(MASK_DEPTH);

  // alpha register and cascade
  logic signed [DATA_W-1:0] alpha_q;
  logic [DATA_W-1:0]        alpha_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      alpha_q     <= '0;
      alpha_out_q <= '0;
    end else if (bus.lr_load_alpha_in) begin
      alpha_q     <= $signed(bus.lr_alpha_in);
      alpha_out_q <= bus.lr_alpha_in;
    end
  end

  // scaled branch: floor((x * alpha) / 2^FRAC), clamped to the word range
  logic signed [DATA_W-1:0]   w_x;
  logic signed [c_prod_w-1:0] w_mul;
  logic signed [c_prod_w-1:0] w_shift;
  logic signed [DATA_W-1:0]   w_prod_sat;
  logic                       w_x_pos;

  assign w_x     = $signed(bus.lr_data_in);
  assign w_mul   = c_prod_w'(w_x) * c_prod_w'(alpha_q);
  assign w_shift = w_mul >>> FRAC;
  assign w_x_pos = !w_x[DATA_W-1] && (w_x != '0);

  always_comb begin
    w_prod_sat = w_shift[DATA_W-1:0];
    if (w_shift > c_sat_max) begin
      w_prod_sat = c_sat_max[DATA_W-1:0];
    end else if (w_shift < c_sat_min) begin
      w_prod_sat = c_sat_min[DATA_W-1:0];
    end
  end

  // derivative-mask FIFO
  logic [MASK_DEPTH-1:0] mask_mem_q;
  logic [c_mask_aw-1:0]  mask_wptr_q;
  logic [c_mask_aw-1:0]  mask_rptr_q;
  logic [c_mask_aw:0]    mask_cnt_q;
  logic                  w_fwd_beat;
  logic                  w_bwd_beat;
  logic                  w_mask_full;
  logic                  w_mask_empty;
  logic                  w_mask_push;
  logic                  w_mask_pop;
  logic                  w_mask_ovf;
  logic                  w_mask_unf;
  logic                  w_mask_head;

  assign w_fwd_beat   = bus.lr_valid_in && !bus.lr_backward_in;
  assign w_bwd_beat   = bus.lr_valid_in &&  bus.lr_backward_in;
  assign w_mask_full  = (mask_cnt_q == c_mask_full);
  assign w_mask_empty = (mask_cnt_q == '0);
  assign w_mask_push  = w_fwd_beat && !bus.lr_mask_clear_in && !w_mask_full;
  assign w_mask_pop   = w_bwd_beat && !bus.lr_mask_clear_in && !w_mask_empty;
  assign w_mask_ovf   = w_fwd_beat && !bus.lr_mask_clear_in &&  w_mask_full;
  // a backward beat during a clear sees the FIFO as already flushed
  assign w_mask_unf   = w_bwd_beat && (bus.lr_mask_clear_in || w_mask_empty);
  assign w_mask_head  = w_mask_pop ? mask_mem_q[mask_rptr_q] : 1'b0;

  always_ff @(posedge clk) begin
    if (w_mask_push) begin
      mask_mem_q[mask_wptr_q] <= w_x_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.lr_mask_clear_in) begin
      mask_wptr_q <= '0;
      mask_rptr_q <= '0;
      mask_cnt_q  <= '0;
    end else begin
      if (w_mask_push) begin
        mask_wptr_q <= mask_wptr_q + 1'b1;
      end
      if (w_mask_pop) begin
        mask_rptr_q <= mask_rptr_q + 1'b1;
      end
      case ({w_mask_push, w_mask_pop})
        2'b10:   mask_cnt_q <= mask_cnt_q + 1'b1;
        2'b01:   mask_cnt_q <= mask_cnt_q - 1'b1;
        default: mask_cnt_q <= mask_cnt_q;
      endcase
    end
  end

  // stage 1: the mask bit selects pass-through vs scaled in both modes
  logic                     s1_valid_q;
  logic signed [DATA_W-1:0] s1_x_q;
  logic signed [DATA_W-1:0] s1_prod_q;
  logic                     s1_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_prod_q  <= '0;
      s1_mask_q  <= 1'b0;
    end else begin
      s1_valid_q <= bus.lr_valid_in;
      if (bus.lr_valid_in) begin
        s1_x_q    <= w_x;
        s1_prod_q <= w_prod_sat;
        s1_mask_q <= bus.lr_backward_in ? w_mask_head : w_x_pos;
      end
    end
  end

  // stage 2 result, written straight into the output FIFO
  logic [DATA_W-1:0] w_y;
  assign w_y = s1_mask_q ? s1_x_q : s1_prod_q;

  // output FIFO with registered head for first-word fall-through
  logic [DATA_W-1:0]   out_mem_q [OUT_DEPTH];
  logic [c_out_aw-1:0] out_wptr_q, out_wptr_d;
  logic [c_out_aw-1:0] out_rptr_q, out_rptr_d;
  logic [c_out_aw:0]   out_cnt_q,  out_cnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                w_out_full;
  logic                w_out_pop;
  logic                w_out_wr;
  logic                w_out_ovf;

  assign w_out_full = (out_cnt_q == c_out_full);
  assign w_out_pop  = valid_out_q && bus.lr_ready_in;
  assign w_out_wr   = s1_valid_q && (!w_out_full || w_out_pop);
  assign w_out_ovf  = s1_valid_q &&   w_out_full && !w_out_pop;

  always_comb begin
    out_wptr_d  = out_wptr_q;
    out_rptr_d  = out_rptr_q;
    out_cnt_d   = out_cnt_q;
    data_out_d  = data_out_q;
    if (w_out_wr) begin
      out_wptr_d = out_wptr_q + 1'b1;
    end
    if (w_out_pop) begin
      out_rptr_d = out_rptr_q + 1'b1;
    end
    case ({w_out_wr, w_out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
    valid_out_d = (out_cnt_d != '0);
    // new word becomes head when nothing older survives this cycle
    if (w_out_wr && ((out_cnt_q == '0) || ((out_cnt_q == 1) && w_out_pop))) begin
      data_out_d = w_y;
    end else if (valid_out_d) begin
      data_out_d = out_mem_q[out_rptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (w_out_wr) begin
      out_mem_q[out_wptr_q] <= w_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_cnt_q   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      out_wptr_q  <= out_wptr_d;
      out_rptr_q  <= out_rptr_d;
      out_cnt_q   <= out_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // sticky loss flags
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | w_mask_ovf | w_out_ovf;
      underflow_q <= underflow_q | w_mask_unf;
    end
  end

  assign bus.lr_alpha_out     = alpha_out_q;
  assign bus.lr_data_out      = data_out_q;
  assign bus.lr_valid_out     = valid_out_q;
  assign bus.lr_overflow_out  = overflow_q;
  assign bus.lr_underflow_out = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_leaky_relu_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_leaky_relu_stage : directed vectors against a queue-based reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_leaky_relu_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  leaky_relu_stage_if #(.DATA_W(16)) bus ();

  leaky_relu_stage #(
    .DATA_W(16), .FRAC(8), .OUT_DEPTH(8), .MASK_DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // reference arithmetic: floor(x*alpha/256) clamped to 16-bit signed
  function automatic logic [15:0] leak(input logic [15:0] x, input logic [15:0] a);
    longint p;
    p = longint'($signed(x)) * longint'($signed(a));
    p = p >>> 8;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  // model state
  typedef struct { logic [15:0] val; int due; } pend_t;
  logic [15:0] m_alpha, m_alpha_out, m_last;
  logic        m_ovf, m_unf;
  logic [15:0] m_out[$];
  bit          m_mask[$];
  pend_t       m_pend[$];
  int          cyc;
  logic [15:0] got[$];
  logic [15:0] ew[$];

  initial begin : model
    logic [15:0] x, y;
    bit          mk;
    m_alpha = '0; m_alpha_out = '0; m_last = '0; m_ovf = 0; m_unf = 0; cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_out.delete(); m_mask.delete(); m_pend.delete();
        m_alpha = '0; m_alpha_out = '0; m_ovf = 0; m_unf = 0;
      end else begin
        if (m_out.size() != 0 && bus.lr_ready_in) void'(m_out.pop_front());
        while (m_pend.size() != 0 && m_pend[0].due <= cyc) begin
          if (m_out.size() < 8) m_out.push_back(m_pend[0].val);
          else m_ovf = 1;
          void'(m_pend.pop_front());
        end
        if (bus.lr_valid_in) begin
          x = bus.lr_data_in;
          if (!bus.lr_backward_in) begin
            mk = ($signed(x) > 0);
            if (!bus.lr_mask_clear_in) begin
              if (m_mask.size() < 64) m_mask.push_back(mk);
              else m_ovf = 1;
            end
          end else if (bus.lr_mask_clear_in || m_mask.size() == 0) begin
            mk = 0;
            m_unf = 1;
          end else begin
            mk = m_mask.pop_front();
          end
          y = mk ? x : leak(x, m_alpha);
          m_pend.push_back('{y, cyc + 1});
        end
        if (bus.lr_mask_clear_in) m_mask.delete();
        if (bus.lr_load_alpha_in) begin
          m_alpha     = bus.lr_alpha_in;
          m_alpha_out = bus.lr_alpha_in;
        end
      end
      if (m_out.size() != 0) m_last = m_out[0];
      if (rst) m_last = '0;
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("valid_out", bus.lr_valid_out, m_out.size() != 0);
      check("data_out", bus.lr_data_out, m_last);
      check("overflow", bus.lr_overflow_out, m_ovf);
      check("underflow", bus.lr_underflow_out, m_unf);
      check("alpha_out", bus.lr_alpha_out, m_alpha_out);
      if (!rst && bus.lr_valid_out && bus.lr_ready_in) got.push_back(bus.lr_data_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic [15:0] x, input logic bwd);
    bus.lr_valid_in = 1'b1; bus.lr_data_in = x; bus.lr_backward_in = bwd;
    tick();
    bus.lr_valid_in = 1'b0; bus.lr_data_in = '0; bus.lr_backward_in = 1'b0;
  endtask

  task automatic load_alpha(input logic [15:0] a);
    bus.lr_load_alpha_in = 1'b1; bus.lr_alpha_in = a;
    tick();
    bus.lr_load_alpha_in = 1'b0;
  endtask

  task automatic mask_clear();
    bus.lr_mask_clear_in = 1'b1;
    tick();
    bus.lr_mask_clear_in = 1'b0;
  endtask

  task automatic check_got(input string name, input logic [15:0] e[$]);
    check($sformatf("%s_count", name), got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], e[i]);
  endtask

  initial begin : stim
    bus.lr_load_alpha_in = 0; bus.lr_alpha_in = '0; bus.lr_data_in = '0;
    bus.lr_valid_in = 0; bus.lr_backward_in = 0; bus.lr_mask_clear_in = 0;
    bus.lr_ready_in = 1;

    idle(3);
    check("rst_valid", bus.lr_valid_out, 0);
    check("rst_data", bus.lr_data_out, 0);
    check("rst_ovf", bus.lr_overflow_out, 0);
    check("rst_unf", bus.lr_underflow_out, 0);
    check("rst_alpha", bus.lr_alpha_out, 0);
    rst = 0;
    idle(2);

    // model arithmetic pinned by hand
    check("model_neg_half", leak(16'hFE00, 16'h0080), 16'hFF00);
    check("model_sat", leak(16'h8000, 16'h0200), 16'h8000);
    check("model_floor", leak(16'hFFFF, 16'h0080), 16'hFFFF);

    // forward basic with two-cycle latency
    load_alpha(16'h0080);
    check("alpha_cascade", bus.lr_alpha_out, 16'h0080);
    got.delete();
    beat(16'h0200, 0);
    check("lat_t1_valid", bus.lr_valid_out, 0);
    beat(16'hFE00, 0);
    check("lat_t2_valid", bus.lr_valid_out, 1);
    check("lat_t2_data", bus.lr_data_out, 16'h0200);
    beat(16'h0000, 0);
    idle(6);
    ew = '{16'h0200, 16'hFF00, 16'h0000};
    check_got("fwd", ew);

    // saturation and floor truncation
    got.delete();
    load_alpha(16'h0200);
    beat(16'h8000, 0);
    load_alpha(16'h0080);
    beat(16'hFFFF, 0);
    idle(5);
    ew = '{16'h8000, 16'hFFFF};
    check_got("sat", ew);

    // backward masking
    mask_clear();
    got.delete();
    beat(16'h0100, 0);
    beat(16'hFF00, 0);
    beat(16'h0400, 1);
    beat(16'h0400, 1);
    idle(6);
    ew = '{16'h0100, 16'hFF80, 16'h0400, 16'h0200};
    check_got("bwd", ew);
    check("bwd_ovf", bus.lr_overflow_out, 0);
    check("bwd_unf", bus.lr_underflow_out, 0);

    // backpressure: ninth word dropped
    got.delete();
    bus.lr_ready_in = 0;
    for (int i = 0; i < 9; i++) beat(16'(16'h0100 * (i + 1)), 0);
    idle(2);
    check("bp_ovf", bus.lr_overflow_out, 1);
    bus.lr_ready_in = 1;
    idle(12);
    ew = '{16'h0100, 16'h0200, 16'h0300, 16'h0400,
           16'h0500, 16'h0600, 16'h0700, 16'h0800};
    check_got("bp", ew);

    // full FIFO with simultaneous push and pop keeps every word
    got.delete();
    bus.lr_ready_in = 0;
    for (int i = 0; i < 9; i++) beat(16'(16'h0011 * (i + 1)), 0);
    bus.lr_ready_in = 1;
    idle(12);
    ew = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055,
           16'h0066, 16'h0077, 16'h0088, 16'h0099};
    check_got("full_pp", ew);

    // clear then backward beat underflows
    mask_clear();
    got.delete();
    beat(16'h0300, 0);
    beat(16'hFD00, 0);
    beat(16'h0001, 0);
    mask_clear();
    beat(16'h0400, 1);
    idle(6);
    ew = '{16'h0300, 16'hFE80, 16'h0001, 16'h0200};
    check_got("unf", ew);
    check("unf_flag", bus.lr_underflow_out, 1);

    // reset with four words queued and two beats in flight
    bus.lr_ready_in = 0;
    for (int i = 0; i < 5; i++) beat(16'(16'h0A01 + i), 0);
    bus.lr_valid_in = 1; bus.lr_data_in = 16'h0A06; rst = 1;
    tick();
    bus.lr_valid_in = 0; bus.lr_data_in = '0; rst = 0;
    check("mrst_valid", bus.lr_valid_out, 0);
    check("mrst_ovf", bus.lr_overflow_out, 0);
    check("mrst_unf", bus.lr_underflow_out, 0);
    check("mrst_alpha", bus.lr_alpha_out, 0);
    got.delete();
    bus.lr_ready_in = 1;
    idle(6);
    ew.delete();
    check_got("mrst_stale", ew);
    beat(16'hFF00, 0);
    beat(16'h0005, 0);
    idle(5);
    ew = '{16'h0000, 16'h0005};
    check_got("mrst_after", ew);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
